// File: rtl/tdm_demux16.sv
// tdm_demux16: serial slot stream to 16-bit parallel frame demultiplexer
module tdm_demux16 #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [0:N-1]     w,
  output logic [SEL_W-1:0] s16,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_nx;
  logic [0:N-1] shadow;
  logic last;
  assign last = s16 == SEL_W'(N - 1);
  // state register
  always_ff @(posedge clock)
    state <= !resetn ? IDLE : state_nx;
  // sync always (re)starts a frame; the last slot returns to idle
  always_comb begin
    state_nx = state;
    if (en) state_nx = sync ? COLLECT : (state == COLLECT && last) ? IDLE : state;
  end
  // busy follows the registered state directly
  always_comb busy = state == COLLECT;
  // slot capture, frame publish and registered status pulses
  always_ff @(posedge clock) begin
    if (!resetn) begin
      shadow <= '0;
      w      <= '0;
      s16    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= busy && en && !sync && last;
      err  <= busy && en && sync;
      if (en && sync) begin
        shadow[0] <= din;
        s16       <= SEL_W'(1);
      end else if (en && busy) begin
        shadow[s16] <= din;
        s16         <= s16 + 1'b1;
        if (last) w <= {shadow[0:N-2], din};
      end
    end
  end
endmodule
